// File: rtl/carry_skip_adder_pkg.sv
// ---------------------------------------------------------------------------
// carry_skip_adder_pkg
// Shared constants and helpers for the carry-skip adder slice.
//   CSA_DEFAULT_WIDTH : default operand/sum width
//   CSA_DEFAULT_BLOCK : default bits per skip block
//   num_blocks()      : number of skip blocks for a WIDTH/BLOCK pair
// ---------------------------------------------------------------------------
package carry_skip_adder_pkg;

    localparam int CSA_DEFAULT_WIDTH = 4;
    localparam int CSA_DEFAULT_BLOCK = 2;

    // WIDTH is expected to be an exact multiple of BLOCK.
    function automatic int num_blocks(input int width, input int block);
        return width / block;
    endfunction

endpackage : carry_skip_adder_pkg

// File: rtl/carry_skip_block.sv
// ---------------------------------------------------------------------------
// carry_skip_block
// One purely combinational ripple block with a propagate-based carry bypass.
//   a, b  : BLOCK-bit operand slices
//   c_in  : carry into the block
//   s     : BLOCK-bit sum slice
//   c_out : carry out of the block, taken from c_in when the whole block
//           propagates, otherwise from the ripple chain
//   P     : block propagate (AND of all per-bit propagates)
// ---------------------------------------------------------------------------
module carry_skip_block #(
    parameter int BLOCK = 2
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             P
);

    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] gen;
    logic [BLOCK:0]   rc;    // ripple carries, rc[0] is the block carry-in

    assign prop = a ^ b;
    assign gen  = a & b;

    always_comb begin
        rc    = '0;
        rc[0] = c_in;
        for (int i = 0; i < BLOCK; i++) begin
            rc[i+1] = gen[i] | (prop[i] & rc[i]);
        end
    end

    assign s = prop ^ rc[BLOCK-1:0];
    assign P = &prop;

    // When every bit propagates the ripple result equals c_in anyway; the
    // mux only shortens the critical path through the block.
    assign c_out = P ? c_in : rc[BLOCK];

endmodule : carry_skip_block

// File: rtl/carry_skip_adder.sv
// ---------------------------------------------------------------------------
// carry_skip_adder
// Registered WIDTH-bit carry-skip adder: {carry, sum} = a + b + cin.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   a, b, cin  : unsigned operands and carry-in
//   in_valid   : operands valid this cycle
//   sum, carry : registered result, held while no new operands arrive
//   out_valid  : sum/carry were updated on the last edge
// Optional build macro CARRY_SKIP_ADDER_INPUT_REG_EN adds an input register
// stage (latency 2 instead of 1, arithmetic unchanged).
//
// Handshake: valid-only, no backpressure. A beat is transferred on every
// rising edge where in_valid is 1; out_valid is a one-cycle pulse per result.
// ---------------------------------------------------------------------------
module carry_skip_adder
    import carry_skip_adder_pkg::*;
#(
    parameter int WIDTH = CSA_DEFAULT_WIDTH,
    parameter int BLOCK = CSA_DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);

    localparam int NB = num_blocks(WIDTH, BLOCK);

    // Operands as seen by the adder core.
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             cin_s;
    logic             valid_s;

`ifdef CARRY_SKIP_ADDER_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s     <= '0;
            b_s     <= '0;
            cin_s   <= 1'b0;
            valid_s <= 1'b0;
        end else begin
            a_s     <= a;
            b_s     <= b;
            cin_s   <= cin;
            valid_s <= in_valid;
        end
    end
`else
    assign a_s     = a;
    assign b_s     = b;
    assign cin_s   = cin;
    assign valid_s = in_valid;
`endif

    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    // Block propagate flags; not needed by the datapath, kept for probing.
    logic [NB-1:0]    blk_p_unused;

    // Each iteration owns its own carry-in/out so the chain is a series of
    // distinct nets rather than one self-referencing vector.
    for (genvar k = 0; k < NB; k++) begin : gen_blk
        logic c_in_k;
        logic c_out_k;

        if (k == 0) begin : gen_first
            assign c_in_k = cin_s;
        end else begin : gen_next
            assign c_in_k = gen_blk[k-1].c_out_k;
        end

        carry_skip_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a     (a_s[k*BLOCK +: BLOCK]),
            .b     (b_s[k*BLOCK +: BLOCK]),
            .c_in  (c_in_k),
            .s     (sum_c[k*BLOCK +: BLOCK]),
            .c_out (c_out_k),
            .P     (blk_p_unused[k])
        );
    end

    assign carry_c = gen_blk[NB-1].c_out_k;

    // Result registers update only on a valid beat; out_valid marks new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_s;
            if (valid_s) begin
                sum   <= sum_c;
                carry <= carry_c;
            end
        end
    end

endmodule : carry_skip_adder

// File: tb/tb_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// tb_carry_skip_adder
// Directed and exhaustive checks of carry_skip_adder at WIDTH=4/BLOCK=2 and
// a second instance at WIDTH=16/BLOCK=4.
// ---------------------------------------------------------------------------
module tb_carry_skip_adder;

`ifdef CARRY_SKIP_ADDER_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0]  a4, b4, sum4;
    logic        cin4, v4, carry4, ov4;
    logic [15:0] a16, b16, sum16;
    logic        cin16, v16, carry16, ov16;

    carry_skip_adder #(.WIDTH(4), .BLOCK(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .in_valid  (v4),
        .sum       (sum4),
        .carry     (carry4),
        .out_valid (ov4)
    );

    carry_skip_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .in_valid  (v16),
        .sum       (sum16),
        .carry     (carry16),
        .out_valid (ov16)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [4:0]  exp4_q[$];
    logic [16:0] exp16_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ov4) begin
            if (exp4_q.size() == 0) check("spurious4", 32'd1, 32'd0);
            else                    check("res4", 32'({carry4, sum4}), 32'(exp4_q.pop_front()));
        end
        if (rst_n && ov16) begin
            if (exp16_q.size() == 0) check("spurious16", 32'd1, 32'd0);
            else                     check("res16", 32'({carry16, sum16}), 32'(exp16_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [4:0] exp);
        @(posedge clk); #1;
        a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
        exp4_q.push_back(exp);
    endtask

    task automatic idle4();
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [16:0] exp);
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = c; v16 = 1'b1;
        exp16_q.push_back(exp);
    endtask

    task automatic idle16();
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        a4 = '0; b4 = '0; cin4 = 1'b0; v4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0; v16 = 1'b0;

        // Reset held from time zero.
        #12;
        check("rst_sum4",   32'(sum4),   32'd0);
        check("rst_carry4", 32'(carry4), 32'd0);
        check("rst_ov4",    32'(ov4),    32'd0);
        check("rst_ov16",   32'(ov16),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain adds, carry generation and full-propagate skip path.
        drive4(4'b1000, 4'b0011, 1'b0, 5'b0_1011);
        drive4(4'b0001, 4'b1010, 1'b1, 5'b0_1100);
        drive4(4'b0110, 4'b0110, 1'b0, 5'b0_1100);
        drive4(4'b0111, 4'b1110, 1'b0, 5'b1_0101);
        drive4(4'b1111, 4'b1110, 1'b1, 5'b1_1110);
        drive4(4'b1001, 4'b0110, 1'b1, 5'b1_0000);
        drive4(4'b1001, 4'b0110, 1'b0, 5'b0_1111);
        idle4();
        repeat (LAT + 2) @(posedge clk);

        // Latency and hold: sampled at edge E, visible after LAT edges.
        drive4(4'b1001, 4'b0100, 1'b0, 5'b0_1101);
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("lat_ov",  32'(ov4), 32'd1);
        check("lat_res", 32'({carry4, sum4}), 32'h0d);
        repeat (3) @(posedge clk);
        #1;
        check("hold_ov",  32'(ov4), 32'd0);
        check("hold_res", 32'({carry4, sum4}), 32'h0d);

        // Exhaustive 4-bit sweep, one vector per cycle.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(4'(i), 4'(j), 1'(c), 5'(i + j + c));
                end
            end
        end
        idle4();
        repeat (LAT + 2) @(posedge clk);

        // Asynchronous reset mid-cycle discards in-flight work.
        drive4(4'b1111, 4'b1111, 1'b1, 5'b1_1111);
        drive4(4'b0101, 4'b0101, 1'b0, 5'b0_1010);
        @(posedge clk); #3;
        rst_n = 1'b0;
        v4 = 1'b0;
        #1;
        check("midrst_sum4",   32'(sum4),   32'd0);
        check("midrst_carry4", 32'(carry4), 32'd0);
        check("midrst_ov4",    32'(ov4),    32'd0);
        exp4_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive4(4'b0010, 4'b0011, 1'b0, 5'b0_0101);
        idle4();
        repeat (LAT + 2) @(posedge clk);

        // 16-bit instance: directed boundary vectors, then random ones.
        drive16(16'hffff, 16'h0001, 1'b0, 17'h1_0000);
        drive16(16'h1234, 16'h4321, 1'b1, 17'h0_5556);
        drive16(16'hf0f0, 16'h0f0f, 1'b1, 17'h1_0000);
        drive16(16'hf0f0, 16'h0f0f, 1'b0, 17'h0_ffff);
        drive16(16'h8000, 16'h8000, 1'b0, 17'h1_0000);
        drive16(16'hffff, 16'hffff, 1'b1, 17'h1_ffff);
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            drive16(ra, rb, rc, 17'({1'b0, ra} + {1'b0, rb} + {16'd0, rc}));
        end
        idle16();
        repeat (LAT + 3) @(posedge clk);

        check("drain4",  32'(exp4_q.size()),  32'd0);
        check("drain16", 32'(exp16_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_carry_skip_adder
